mem_tbus_arb: RTL
=================

// Module: mem_tbus_arb
// PURPOSE
// 2:1 trinity-bus arbiter between load unit (ch LD) and store queue (ch SQ) in front of dcache tbus.
// Locks a channel from grant through operation_done; round-robin fairness; aborts younger-than-flush loads.
// PARAMETERS
// DATA_W    64  width of index, write_data, write_mask, read_data
// OPTYPE_W  2   width of tbus operation_type
// ROBID_W   7   robid width (ROB_SIZE_LOG+1, msb = wrap bit)
// PORTS
// clock                         in   1         single clock, all logic on rising edge
// reset                         in   1         synchronous, active-high
// flush_valid                   in   1         redirect flush
// flush_robid                   in   ROBID_W   flushing instr; strictly younger robids are killed
// load2arb_tbus_index_valid     in   1         LD request; held with payload until ready
// load2arb_tbus_index_ready     out  1         LD request accepted by dcache
// load2arb_tbus_index           in   DATA_W    LD address
// load2arb_tbus_operation_type  in   OPTYPE_W  LD op type
// load2arb_tbus_robid           in   ROBID_W   LD robid, for flush check
// load2arb_tbus_read_data       out  DATA_W    dcache read data, valid with LD done
// load2arb_tbus_operation_done  out  1         LD completion pulse
// sq2arb_tbus_index_valid       in   1         SQ request; held with payload until ready
// sq2arb_tbus_index_ready       out  1         SQ request accepted by dcache
// sq2arb_tbus_index             in   DATA_W    SQ address
// sq2arb_tbus_write_data        in   DATA_W    SQ store data
// sq2arb_tbus_write_mask        in   DATA_W    SQ byte-lane mask
// sq2arb_tbus_operation_type    in   OPTYPE_W  SQ op type
// sq2arb_tbus_operation_done    out  1         SQ completion pulse
// tbus_index_valid              out  1         request to dcache
// tbus_index_ready              in   1         dcache accepts request
// tbus_index                    out  DATA_W    muxed address
// tbus_write_data               out  DATA_W    SQ data when SQ owns, else 0
// tbus_write_mask               out  DATA_W    SQ mask when SQ owns, else 0
// tbus_operation_type           out  OPTYPE_W  muxed op type
// tbus_read_data                in   DATA_W    dcache read data
// tbus_operation_done           in   1         dcache completion pulse
// arb2dcache_flush_valid        out  1         one-cycle cancel of in-flight LD op
// BEHAVIOUR
// - States IDLE, OWN_LD, OWN_SQ, LD_KILL; flag fired (request handshaken) and rr_last (1=SQ granted last).
// - Reset: state IDLE, fired 0, rr_last 1 (LD wins first tie); all outputs 0 from reset cycle on.
// - IDLE: no output valid. LD only -> OWN_LD; SQ only -> OWN_SQ; both -> channel != rr_last. Grant +1 cycle.
// - OWN_x: tbus_* = owner payload; tbus_index_valid = owner valid & !fired; owner ready = tbus_index_ready & !fired.
// - Fire (valid&ready) sets fired; tbus_operation_done -> owner done pulse, -> IDLE, rr_last=owner, fired=0.
// - done may come in the fire cycle; a done with no owner in flight is ignored.
// - Non-owner sees ready=0, done=0. load2arb_tbus_read_data = tbus_read_data when LD done, else 0.
// - robid of LD latched at grant; kill = flush_valid & ((f.msb^r.msb) ^ (f.idx < r.idx)), idx = low bits.
// - Kill in OWN_LD, !fired: -> IDLE next cycle, no dcache flush, no done. Kill in IDLE/OWN_SQ: no effect.
// - Kill in OWN_LD, fired, no done this cycle: arb2dcache_flush_valid=1 one cycle -> LD_KILL.
// - Kill coincident with done: done swallowed (LD gets none), no dcache flush, -> IDLE, rr_last=LD.
// - LD_KILL: no request issued; swallow next tbus_operation_done -> IDLE. SQ ops never flushed.
// TESTING
// - LD-only, robid 5, ready in 1st valid cycle, done 3 later, data 0xDEAD -> LD done 1 cycle, data 0xDEAD.
// - LD and SQ valid same cycle after reset -> LD granted; next IDLE with both valid -> SQ granted.
// - SQ write 0x11 mask 0xFF: tbus_write_* match while SQ owns; 0 when LD owns; SQ done once.
// - LD robid 0x05 fired, flush 0x03 -> dcache flush 1 cycle, LD_KILL, next done swallowed; flush 0x07 no effect.
// - Wrap: LD robid 0x41, flush 0x3F -> killed; LD 0x3F, flush 0x41 -> not killed, LD done normal.

Source files
------------

// File: rtl/mem_tbus_arb.sv
// mem_tbus_arb: 2:1 trinity-bus arbiter placed in front of the dcache tbus.
//   Two requesters: the load unit (LD) and the store queue (SQ).
//   A granted channel keeps the bus from grant until its operation_done.
//   Ties are broken round-robin, and younger-than-flush loads are aborted.
// Ports:
//   clock, reset                    : single rising-edge clock, sync active-high reset
//   flush_valid, flush_robid        : redirect flush; robids strictly younger are killed
//   load2arb_tbus_*                 : LD request (index/op/robid), ready, read data, done
//   sq2arb_tbus_*                   : SQ request (index/data/mask/op), ready, done
//   tbus_*                          : muxed request to dcache, ready, read data, done
//   arb2dcache_flush_valid          : one-cycle cancel of an in-flight LD operation
module mem_tbus_arb #(
  parameter int DATA_W   = 64,
  parameter int OPTYPE_W = 2,
  parameter int ROBID_W  = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_valid,
  input  logic [ROBID_W-1:0]  flush_robid,
  input  logic                load2arb_tbus_index_valid,
  output logic                load2arb_tbus_index_ready,
  input  logic [DATA_W-1:0]   load2arb_tbus_index,
  input  logic [OPTYPE_W-1:0] load2arb_tbus_operation_type,
  input  logic [ROBID_W-1:0]  load2arb_tbus_robid,
  output logic [DATA_W-1:0]   load2arb_tbus_read_data,
  output logic                load2arb_tbus_operation_done,
  input  logic                sq2arb_tbus_index_valid,
  output logic                sq2arb_tbus_index_ready,
  input  logic [DATA_W-1:0]   sq2arb_tbus_index,
  input  logic [DATA_W-1:0]   sq2arb_tbus_write_data,
  input  logic [DATA_W-1:0]   sq2arb_tbus_write_mask,
  input  logic [OPTYPE_W-1:0] sq2arb_tbus_operation_type,
  output logic                sq2arb_tbus_operation_done,
  output logic                tbus_index_valid,
  input  logic                tbus_index_ready,
  output logic [DATA_W-1:0]   tbus_index,
  output logic [DATA_W-1:0]   tbus_write_data,
  output logic [DATA_W-1:0]   tbus_write_mask,
  output logic [OPTYPE_W-1:0] tbus_operation_type,
  input  logic [DATA_W-1:0]   tbus_read_data,
  input  logic                tbus_operation_done,
  output logic                arb2dcache_flush_valid
);

  typedef enum logic [1:0] {IDLE, OWN_LD, OWN_SQ, LD_KILL} state_t;

  state_t             state;
  logic               fired;    // owner's request already handshaken
  logic               rr_last;  // 1 = SQ was granted last
  logic [ROBID_W-1:0] ld_robid;

  // Robids carry a wrap bit in the msb: when the wrap bits differ the
  // index comparison is inverted.
  function automatic logic is_younger(input logic [ROBID_W-1:0] f,
                                      input logic [ROBID_W-1:0] r);
    return (f[ROBID_W-1] ^ r[ROBID_W-1]) ^ (f[ROBID_W-2:0] < r[ROBID_W-2:0]);
  endfunction

  logic own_ld, own_sq, kill, ld_issue, sq_issue, fire, inflight, done_acc;

  always_comb begin
    own_ld   = (state == OWN_LD) && !reset;
    own_sq   = (state == OWN_SQ) && !reset;
    kill     = own_ld && flush_valid && is_younger(flush_robid, ld_robid);
    // A load being killed must not be handed to the dcache in the same cycle,
    // otherwise the bus would be left with an orphan operation.
    ld_issue = own_ld && !fired && !kill;
    sq_issue = own_sq && !fired;
    tbus_index_valid = (ld_issue && load2arb_tbus_index_valid) ||
                       (sq_issue && sq2arb_tbus_index_valid);
    load2arb_tbus_index_ready = ld_issue && tbus_index_ready;
    sq2arb_tbus_index_ready   = sq_issue && tbus_index_ready;
    fire     = tbus_index_valid && tbus_index_ready;
    // Done may arrive in the fire cycle; a done with nothing in flight is ignored.
    inflight = fired || fire;
    done_acc = tbus_operation_done && inflight;

    load2arb_tbus_operation_done = own_ld && done_acc && !kill;
    load2arb_tbus_read_data      = load2arb_tbus_operation_done ? tbus_read_data : '0;
    sq2arb_tbus_operation_done   = own_sq && done_acc;
    arb2dcache_flush_valid       = kill && fired && !tbus_operation_done;

    tbus_index          = '0;
    tbus_operation_type = '0;
    tbus_write_data     = '0;
    tbus_write_mask     = '0;
    if (own_ld) begin
      tbus_index          = load2arb_tbus_index;
      tbus_operation_type = load2arb_tbus_operation_type;
    end else if (own_sq) begin
      tbus_index          = sq2arb_tbus_index;
      tbus_operation_type = sq2arb_tbus_operation_type;
      tbus_write_data     = sq2arb_tbus_write_data;
      tbus_write_mask     = sq2arb_tbus_write_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      fired   <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          fired <= 1'b0;
          if (load2arb_tbus_index_valid && (!sq2arb_tbus_index_valid || rr_last)) begin
            state    <= OWN_LD;
            ld_robid <= load2arb_tbus_robid;
          end else if (sq2arb_tbus_index_valid) begin
            state <= OWN_SQ;
          end
        end
        OWN_LD: begin
          if (kill) begin
            // Fired and no done: dcache must be cancelled and its done swallowed.
            state   <= (fired && !tbus_operation_done) ? LD_KILL : IDLE;
            fired   <= 1'b0;
            rr_last <= 1'b0;
          end else if (done_acc) begin
            state   <= IDLE;
            fired   <= 1'b0;
            rr_last <= 1'b0;
          end else if (fire) begin
            fired <= 1'b1;
          end
        end
        OWN_SQ: begin
          if (done_acc) begin
            state   <= IDLE;
            fired   <= 1'b0;
            rr_last <= 1'b1;
          end else if (fire) begin
            fired <= 1'b1;
          end
        end
        LD_KILL: begin
          fired <= 1'b0;
          if (tbus_operation_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          fired <= 1'b0;
        end
      endcase
    end
  end

endmodule
